// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path (and later the transmit path).
// Contents:
//   rx_state_t - receiver FSM states
//   OS_MID     - oversample index at the middle of a bit (start-bit check)
//   OS_LAST    - oversample index at which data and stop bits are sampled
//   NBITS      - data bits per frame
//   baud_div() - system clocks per oversample tick
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [3:0] OS_MID  = 4'd7;
  localparam logic [3:0] OS_LAST = 4'd15;
  localparam int         NBITS   = 8;

  // Clocks per 1/16-bit tick, integer division. Callers must keep the result >= 2.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous reset, active low
//   clr   in  holds the counter at zero while high
//   tick  out one-cycle strobe every DIV clocks after clr is released
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = $clog2(DIV);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST) && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_unit.sv
// UART 8N1 receiver feeding operand bytes to the ID stage.
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous reset, active low
//   UART_RX   in  raw serial line, idle high, asynchronous to clk
//   rx_data   out last accepted byte, held until the next accepted byte
//   signal    out one-cycle strobe: rx_data/flag updated this cycle
//   flag      out operand slot of rx_data (0 = operand 1, 1 = operand 2)
//   frame_err out one-cycle strobe: stop bit sampled low, byte discarded
//
// Output protocol: signal and frame_err are single-cycle strobes with no
// ready/backpressure. The consumer must capture rx_data/flag in the cycle
// signal is high; they stay stable until the next accepted byte, which comes
// at the earliest 160*DIV cycles later. The two strobes are never high together.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int OS     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       signal,
  output logic       flag,
  output logic       frame_err
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);

  logic                    r_sync1;
  logic                    r_sync2;
  logic                    r_prev;
  rx_state_t               r_state;
  logic [$clog2(OS)-1:0]   r_os_cnt;
  logic [2:0]              r_bit_cnt;
  logic [NBITS-1:0]        r_shift;
  logic                    r_idx;
  logic [7:0]              r_rx_data;
  logic                    r_flag;
  logic                    r_signal;
  logic                    r_frame_err;

  logic w_line;
  logic w_fall;
  logic w_tick;
  logic w_tick_clr;

  assign w_line     = r_sync2;
  assign w_fall     = r_prev && !r_sync2;
  // Holding the divider cleared in IDLE makes the first tick land exactly
  // DIV cycles after start detection, so all sample points are frame-relative.
  assign w_tick_clr = (r_state == IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_tick_clr),
    .tick  (w_tick)
  );

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= UART_RX;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_os_cnt    <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_idx       <= 1'b0;
      r_rx_data   <= 8'h00;
      r_flag      <= 1'b0;
      r_signal    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_signal    <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          // Edge-triggered: a line stuck low (break) cannot restart a frame.
          if (w_fall) begin
            r_state   <= START;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_os_cnt == OS_MID) begin
              r_state   <= w_line ? IDLE : DATA;
              r_os_cnt  <= '0;
              r_bit_cnt <= '0;
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_os_cnt == OS_LAST) begin
              r_shift  <= {w_line, r_shift[NBITS-1:1]};
              r_os_cnt <= '0;
              if (r_bit_cnt == 3'(NBITS - 1)) begin
                r_state   <= STOP;
                r_bit_cnt <= '0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_os_cnt == OS_LAST) begin
              if (w_line) begin
                r_rx_data <= r_shift;
                r_flag    <= r_idx;
                r_idx     <= ~r_idx;
                r_signal  <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
              r_state   <= IDLE;
              r_os_cnt  <= '0;
              r_bit_cnt <= '0;
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign signal    = r_signal;
  assign flag      = r_flag;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_unit.sv
`timescale 1ns/1ps
module tb_uart_rx_unit;
  import uart_pkg::*;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 10_000;
  localparam int P_NOM  = 160;

  logic       clk;
  logic       rst_n;
  logic       UART_RX;
  logic [7:0] rx_data;
  logic       signal;
  logic       flag;
  logic       frame_err;

  uart_rx_unit #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .OS     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .UART_RX   (UART_RX),
    .rx_data   (rx_data),
    .signal    (signal),
    .flag      (flag),
    .frame_err (frame_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  // Entry: {is_frame_err, expected flag, expected rx_data}
  logic [9:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int n_ev     = 0;
  int sig_cyc  = 0;
  int t_fall   = 0;
  logic prev_sig = 1'b0;

  // Behavioural model: alternating operand slot, last accepted byte/slot.
  bit         m_idx;
  logic [7:0] m_last_data;
  bit         m_last_flag;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (signal || frame_err)) begin
      logic [9:0] e;
      n_ev++;
      chk("no_dual_pulse", int'(signal & frame_err), 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: signal=%0b frame_err=%0b rx_data=0x%0h required no event (cycle %0d)",
                 signal, frame_err, rx_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", int'(frame_err), int'(e[9]));
        chk("flag", int'(flag), int'(e[8]));
        chk("rx_data", int'(rx_data), int'(e[7:0]));
      end
      if (signal) sig_cyc = cyc;
    end
    if (rst_n && signal) chk("signal_one_cycle", int'(prev_sig), 0);
    prev_sig = signal;
  end

  // ---------------- model helpers ----------------
  task automatic model_track(input logic [7:0] d, input bit ok);
    if (ok) begin
      m_last_data = d;
      m_last_flag = m_idx;
      m_idx       = ~m_idx;
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input bit ok);
    if (ok) exp_q.push_back({1'b0, m_idx, d});
    else    exp_q.push_back({1'b1, m_last_flag, m_last_data});
    model_track(d, ok);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge, returns at a negedge; line stays at the stop level.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int p);
    UART_RX = 1'b0;
    t_fall  = cyc;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      repeat (p) @(negedge clk);
    end
    UART_RX = stop_ok;
    repeat (p) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    UART_RX = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_flag", int'(flag), 0);
    chk("reset_signal", int'(signal), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_state", int'(dut.r_state), int'(IDLE));
    exp_q.delete();
    m_idx       = 1'b0;
    m_last_data = 8'h00;
    m_last_flag = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         rst;
    logic [7:0] data;
    bit         stop_ok;
    int         period;
    int         low_hold;
    int         gap;
    bit         e_err;
    bit         e_flag;
    logic [7:0] e_data;
  } row_t;

  row_t rows[9];

  initial begin
    logic [7:0] d;
    bit         ok;
    int         p;
    int         n_before;

    rst_n   = 1'b0;
    UART_RX = 1'b1;

    //          rst  data   ok period hold gap  err flag exp_data
    rows[0] = '{1'b1, 8'h5A, 1'b1, 160,   0,  40, 1'b0, 1'b0, 8'h5A};
    rows[1] = '{1'b1, 8'h03, 1'b1, 160,   0,   0, 1'b0, 1'b0, 8'h03};
    rows[2] = '{1'b0, 8'h7F, 1'b1, 160,   0,   0, 1'b0, 1'b1, 8'h7F};
    rows[3] = '{1'b0, 8'hFF, 1'b1, 160,   0,  40, 1'b0, 1'b0, 8'hFF};
    rows[4] = '{1'b1, 8'h10, 1'b1, 160,   0,  40, 1'b0, 1'b0, 8'h10};
    rows[5] = '{1'b0, 8'hA5, 1'b0, 160, 480,  40, 1'b1, 1'b0, 8'h10};
    rows[6] = '{1'b0, 8'h22, 1'b1, 160,   0,  40, 1'b0, 1'b1, 8'h22};
    rows[7] = '{1'b1, 8'hC3, 1'b1, 155,   0,  40, 1'b0, 1'b0, 8'hC3};
    rows[8] = '{1'b0, 8'hC3, 1'b1, 165,   0,  40, 1'b0, 1'b1, 8'hC3};

    for (int i = 0; i < 9; i++) begin
      if (rows[i].rst) do_reset();
      exp_q.push_back({rows[i].e_err, rows[i].e_flag, rows[i].e_data});
      model_track(rows[i].data, rows[i].stop_ok);
      send_frame(rows[i].data, rows[i].stop_ok, rows[i].period);
      if (!rows[i].stop_ok) begin
        repeat (rows[i].low_hold) @(negedge clk);
        chk("break_no_retrigger_state", int'(dut.r_state), int'(IDLE));
        UART_RX = 1'b1;
      end
      repeat (rows[i].gap) @(negedge clk);
      if (i == 0) chk("latency_cycles", sig_cyc - t_fall, 1523);
      chk("row_queue_drained", exp_q.size(), 0);
    end

    // ---------------- glitch on idle line ----------------
    do_reset();
    n_before = n_ev;
    UART_RX = 1'b0;
    repeat (40) @(negedge clk);
    UART_RX = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_no_event", n_ev, n_before);
    chk("glitch_state_idle", int'(dut.r_state), int'(IDLE));
    model_frame(8'h11, 1'b1);
    send_frame(8'h11, 1'b1, P_NOM);
    repeat (40) @(negedge clk);
    chk("glitch_followup_drained", exp_q.size(), 0);

    // ---------------- reset during data bit 4 of operand 2 ----------------
    do_reset();
    model_frame(8'h33, 1'b1);
    send_frame(8'h33, 1'b1, P_NOM);
    d = 8'h96;
    UART_RX = 1'b0;
    repeat (P_NOM) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      UART_RX = d[i];
      repeat (P_NOM) @(negedge clk);
    end
    UART_RX = d[4];
    repeat (P_NOM / 2) @(negedge clk);
    chk("pre_reset_rx_data", int'(rx_data), 8'h33);
    do_reset();
    model_frame(8'h44, 1'b1);
    send_frame(8'h44, 1'b1, P_NOM);
    repeat (40) @(negedge clk);
    chk("post_reset_drained", exp_q.size(), 0);

    // ---------------- randomized frames vs. model ----------------
    for (int n = 0; n < 8; n++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      p  = int'($urandom_range(155, 165));
      model_frame(d, ok);
      send_frame(d, ok, p);
      if (!ok) begin
        repeat ($urandom_range(0, 300)) @(negedge clk);
        UART_RX = 1'b1;
        repeat (20 + $urandom_range(0, 20)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
    end

    repeat (200) @(negedge clk);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
